// File: rtl/regfile_exec_stage_pkg.sv
// Shared constants and helpers for the register-file / execute stage.
package regfile_exec_stage_pkg;

    // Datapath width and register count (register count equals one-hot select width)
    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREG  = 32;

    // ALU operation encodings carried on S
    localparam logic [2:0] ALU_XOR = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_INV = 3'b111;

    // Select-bus mask that drops register 0 (hard-wired zero, never forwarded)
    localparam logic [NREG-1:0] SEL_NO_R0 = {{(NREG-1){1'b1}}, 1'b0};

    // Sign-extend a 16-bit immediate to the datapath width
    function automatic logic [WIDTH-1:0] sign_ext16(input logic [15:0] v);
        return {{(WIDTH-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/regfile_exec_stage_alu32.sv
// Combinational ALU: add/subtract with carry-in and bitwise logic ops.
// valid_o is low for undefined op codes so the caller can suppress writes.
module regfile_exec_stage_alu32
    import regfile_exec_stage_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       s_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] cin_ext;

    assign cin_ext = {{(WIDTH-1){1'b0}}, cin_i};

    // Decode the op and compute the result; unknown ops yield zero and valid_o=0
    always_comb begin
        result_o = '0;
        valid_o  = 1'b1;
        case (s_i)
            ALU_ADD: result_o = a_i + b_i + cin_ext;
            ALU_SUB: result_o = a_i + ~b_i + cin_ext;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            default: begin
                result_o = '0;
                valid_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_exec_stage.sv
// Execute stage: 32x32 one-hot register file, ID/EX operand latches, ALU,
// EX/WB result latch and write-back, with EX- and WB-level operand forwarding
// so dependent instructions can issue back to back.
module regfile_exec_stage
    import regfile_exec_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ibus0,
    input  logic [NREG-1:0]  Aselect,
    input  logic [NREG-1:0]  Bselect,
    input  logic [NREG-1:0]  Dselect,
    input  logic             Imm,
    input  logic [2:0]       S,
    input  logic             Cin,
    output logic [WIDTH-1:0] abus,
    output logic [WIDTH-1:0] bbus,
    output logic [WIDTH-1:0] dbus
);

    // Register file and pipeline state
    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] dbus_q, dbus_d;
    logic [NREG-1:0]  dsel_wb_q, dsel_wb_d;

    // Read-port results and forwarding decisions
    logic [WIDTH-1:0] rf_a, rf_b;
    logic             ex_hit_a, ex_hit_b;
    logic             wb_hit_a, wb_hit_b;

    // ALU
    logic [WIDTH-1:0] alu_result;
    logic             alu_valid;

    // Only the low half of the instruction word carries the immediate
    logic unused_ibus_hi;
    assign unused_ibus_hi = ^ibus0[WIDTH-1:16];

    // One-hot read: OR of every selected register; register 0 is excluded so it reads 0
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        for (int i = 1; i < NREG; i++) begin
            if (Aselect[i]) rf_a = rf_a | rf_q[i];
            if (Bselect[i]) rf_b = rf_b | rf_q[i];
        end
    end

    // Forwarding hits: EX needs a valid op; bit 0 never matches either path
    always_comb begin
        ex_hit_a = alu_valid && ((Aselect & Dselect & SEL_NO_R0) != '0);
        ex_hit_b = alu_valid && ((Bselect & Dselect & SEL_NO_R0) != '0);
        wb_hit_a = (Aselect & dsel_wb_q & SEL_NO_R0) != '0;
        wb_hit_b = (Bselect & dsel_wb_q & SEL_NO_R0) != '0;
    end

    // Operand next-state with priority EX > WB > register file
    always_comb begin
        a_d = rf_a;
        b_d = rf_b;
        if (ex_hit_a) begin
            a_d = alu_result;
        end else if (wb_hit_a) begin
            a_d = dbus_q;
        end
        if (ex_hit_b) begin
            b_d = alu_result;
        end else if (wb_hit_b) begin
            b_d = dbus_q;
        end
        imm_d = sign_ext16(ibus0[15:0]);
    end

    // Execute-stage operand presentation
    always_comb begin
        abus = a_q;
        bbus = Imm ? imm_q : b_q;
    end

    regfile_exec_stage_alu32 u_alu (
        .a_i      (abus),
        .b_i      (bbus),
        .s_i      (S),
        .cin_i    (Cin),
        .result_o (alu_result),
        .valid_o  (alu_valid)
    );

    // EX/WB next-state: result is always latched, invalid ops drop their destination
    always_comb begin
        dbus_d    = alu_result;
        dsel_wb_d = alu_valid ? Dselect : '0;
    end

    assign dbus = dbus_q;

    // ID/EX and EX/WB pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            dbus_q    <= '0;
            dsel_wb_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            dbus_q    <= dbus_d;
            dsel_wb_q <= dsel_wb_d;
        end
    end

    // Register file write-back; reset wins over a same-cycle write, r0 stays zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (dsel_wb_q[i]) rf_q[i] <= dbus_q;
            end
        end
    end

endmodule

// File: tb/tb_regfile_exec_stage.sv
// Directed self-checking bench for regfile_exec_stage. Each issued instruction
// pushes its expected operands/result to a scoreboard queue; the entry is
// popped and compared when the instruction reaches execute and the EX/WB latch.
module tb_regfile_exec_stage;
    import regfile_exec_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] ibus0;
    logic [31:0] Aselect;
    logic [31:0] Bselect;
    logic [31:0] Dselect;
    logic        Imm;
    logic [2:0]  S;
    logic        Cin;
    logic [31:0] abus;
    logic [31:0] bbus;
    logic [31:0] dbus;

    int checks;
    int errors;

    typedef struct {
        logic        chk;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ed;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    // Execute-stage fields of the previously issued instruction
    logic [31:0] p_dsel;
    logic        p_imm;
    logic [2:0]  p_s;
    logic        p_cin;

    regfile_exec_stage dut (
        .clk     (clk),
        .reset   (reset),
        .ibus0   (ibus0),
        .Aselect (Aselect),
        .Bselect (Bselect),
        .Dselect (Dselect),
        .Imm     (Imm),
        .S       (S),
        .Cin     (Cin),
        .abus    (abus),
        .bbus    (bbus),
        .dbus    (dbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] oh(input int i);
        logic [31:0] one;
        one = 32'd1;
        return one << i;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one instruction: its read fields now, its execute fields next call
    task automatic issue(input logic [31:0] asel, input logic [31:0] bsel,
                         input logic [15:0] imm, input logic [31:0] dsel,
                         input logic immf, input logic [2:0] s, input logic cin,
                         input logic chk, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ed, input string tag);
        exp_t e;
        Aselect = asel;
        Bselect = bsel;
        ibus0   = {16'hDEAD, imm};
        Dselect = p_dsel;
        Imm     = p_imm;
        S       = p_s;
        Cin     = p_cin;
        p_dsel  = dsel;
        p_imm   = immf;
        p_s     = s;
        p_cin   = cin;
        #1;
        if (exp_q.size() > 0 && exp_q[0].chk) begin
            check({exp_q[0].tag, ".abus"}, abus, exp_q[0].ea);
            check({exp_q[0].tag, ".bbus"}, bbus, exp_q[0].eb);
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) check({e.tag, ".dbus"}, dbus, e.ed);
        end
        e.chk = chk;
        e.ea  = ea;
        e.eb  = eb;
        e.ed  = ed;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic nop();
        issue(32'd0, 32'd0, 16'd0, 32'd0, 1'b0, ALU_INV, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, "nop");
    endtask

    // Read register i through the OR path with a zero B operand
    task automatic rd(input int i, input logic [31:0] expv, input string tag);
        issue(oh(i), 32'd0, 16'd0, 32'd0, 1'b0, ALU_OR, 1'b0, 1'b1, expv, 32'd0, expv, tag);
    endtask

    // Sequence of directed steps
    initial begin
        checks = 0;
        errors = 0;
        p_dsel = '0;
        p_imm  = 1'b0;
        p_s    = ALU_INV;
        p_cin  = 1'b0;

        // Reset with garbage inputs
        reset   = 1'b1;
        Aselect = 32'hFFFF_FFFF;
        Bselect = 32'hA5A5_5A5A;
        Dselect = 32'hFFFF_FFFF;
        ibus0   = 32'h1234_8765;
        Imm     = 1'b1;
        S       = ALU_ADD;
        Cin     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.abus", abus, 32'd0);
        check("reset.bbus", bbus, 32'd0);
        check("reset.dbus", dbus, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) rd(i, 32'd0, $sformatf("rst_r%0d", i));

        // addi/addi then dependent add with WB (A) and EX (B) forwarding
        issue(oh(0), 32'd0, 16'd5, oh(1), 1'b1, ALU_ADD, 1'b0, 1'b1,
              32'd0, 32'd5, 32'd5, "addi_r1");
        issue(oh(0), 32'd0, 16'hFFFD, oh(2), 1'b1, ALU_ADD, 1'b0, 1'b1,
              32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, "addi_r2");
        issue(oh(1), oh(2), 16'd0, oh(3), 1'b0, ALU_ADD, 1'b0, 1'b1,
              32'd5, 32'hFFFF_FFFD, 32'd2, "add_r3");

        // Subtract and logic ops with r1=0x0F0F, r2=0x00FF
        issue(oh(0), 32'd0, 16'h0F0F, oh(1), 1'b1, ALU_ADD, 1'b0, 1'b1,
              32'd0, 32'h0F0F, 32'h0F0F, "addi_r1b");
        issue(oh(0), 32'd0, 16'h00FF, oh(2), 1'b1, ALU_ADD, 1'b0, 1'b1,
              32'd0, 32'h00FF, 32'h00FF, "addi_r2b");
        issue(oh(1), oh(2), 16'd0, oh(6), 1'b0, ALU_SUB, 1'b1, 1'b1,
              32'h0F0F, 32'h00FF, 32'h0E10, "sub");
        issue(oh(1), oh(2), 16'd0, oh(7), 1'b0, ALU_AND, 1'b0, 1'b1,
              32'h0F0F, 32'h00FF, 32'h000F, "and");
        issue(oh(1), oh(2), 16'd0, 32'd0, 1'b0, ALU_OR, 1'b0, 1'b1,
              32'h0F0F, 32'h00FF, 32'h0FFF, "or");
        issue(oh(1), oh(2), 16'd0, 32'd0, 1'b0, ALU_XOR, 1'b0, 1'b1,
              32'h0F0F, 32'h00FF, 32'h0FF0, "xor");
        nop();
        nop();
        rd(3, 32'd2, "rd_r3");
        rd(6, 32'h0E10, "rd_r6");

        // Register 0 is never written and never forwarded
        issue(oh(0), 32'd0, 16'd7, oh(1), 1'b1, ALU_ADD, 1'b0, 1'b1,
              32'd0, 32'd7, 32'd7, "addi_r1c");
        issue(oh(1), oh(1), 16'd0, oh(0), 1'b0, ALU_ADD, 1'b0, 1'b1,
              32'd7, 32'd7, 32'd14, "add_r0");
        issue(oh(0), oh(0), 16'd0, oh(8), 1'b0, ALU_OR, 1'b0, 1'b1,
              32'd0, 32'd0, 32'd0, "rd_r0_nofwd");
        nop();
        nop();
        rd(0, 32'd0, "rd_r0");
        rd(1, 32'd7, "rd_r1");

        // Invalid op: result latched but r4 keeps 0x1234, no EX forward either
        issue(oh(0), 32'd0, 16'h1234, oh(4), 1'b1, ALU_ADD, 1'b0, 1'b1,
              32'd0, 32'h1234, 32'h1234, "addi_r4");
        issue(oh(1), oh(1), 16'd0, oh(4), 1'b0, ALU_INV, 1'b0, 1'b0,
              32'd0, 32'd0, 32'd0, "inv_r4");
        issue(oh(4), 32'd0, 16'd0, oh(9), 1'b0, ALU_OR, 1'b0, 1'b1,
              32'h1234, 32'd0, 32'h1234, "rd_r4_fwd");
        nop();
        nop();
        rd(4, 32'h1234, "rd_r4");
        rd(9, 32'h1234, "rd_r9");

        // Multi-hot read selects and multi-hot write-back
        issue(oh(1) | oh(4), oh(9), 16'd0, oh(10) | oh(11), 1'b0, ALU_AND, 1'b0, 1'b1,
              32'h1237, 32'h1234, 32'h1234, "multihot");
        nop();
        nop();
        rd(10, 32'h1234, "rd_r10");
        rd(11, 32'h1234, "rd_r11");

        // Reset while add r5,r1,r1 is in execute
        issue(oh(1), oh(1), 16'd0, oh(5), 1'b0, ALU_ADD, 1'b0, 1'b0,
              32'd0, 32'd0, 32'd0, "add_r5");
        exp_q.delete();
        reset   = 1'b1;
        Aselect = oh(1);
        Bselect = oh(1);
        Dselect = oh(5);
        Imm     = 1'b0;
        S       = ALU_ADD;
        Cin     = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        p_dsel = '0;
        p_imm  = 1'b0;
        p_s    = ALU_INV;
        p_cin  = 1'b0;
        check("midrst.dbus", dbus, 32'd0);
        check("midrst.abus", abus, 32'd0);
        nop();
        nop();
        rd(5, 32'd0, "rd_r5");
        rd(1, 32'd0, "rd_r1_cleared");
        nop();
        nop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_exec_stage.md
Name: regfile_exec_stage

Overview:
Execute stage directly downstream of the instruction decode stage. It consumes the one-hot select buses Aselect, Bselect and Dselect, plus Imm, S, Cin and the fetched instruction word ibus0.
It contains the 32x32 register file, the ID/EX operand latches, the ALU, the EX/WB result latch and write-back. Two-level forwarding lets back-to-back dependent instructions run without stalls.

Parameters:
WIDTH, 32, datapath width in bits
NREG, 32, number of registers; equals the one-hot select width (fixed at 32)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
ibus0  input  32  instruction word; ibus0[15:0] is the immediate, valid in the same cycle as Aselect/Bselect
Aselect  input  32  one-hot rs select (combinational from decode, cycle N)
Bselect  input  32  one-hot rt select (combinational from decode, cycle N)
Dselect  input  32  one-hot destination select (registered by decode, valid cycle N+1)
Imm  input  1  1 = B operand is the sign-extended immediate (valid cycle N+1)
S  input  3  ALU op (valid cycle N+1)
Cin  input  1  ALU carry-in (valid cycle N+1)
abus  output  32  latched A operand presented to the ALU
bbus  output  32  B operand after the immediate mux
dbus  output  32  registered ALU result (EX/WB latch)

Behaviour:
- Reset (sync, on the clk edge with reset=1):
  - all 32 registers, the ID/EX latches (a_q, b_q, imm_q), the EX/WB latch dbus and dsel_wb are cleared to 0.
  - abus, bbus and dbus read 0 on the first cycle after reset.
  - reset overrides any write in the same cycle.
- Cycle N (read):
  - A operand = OR-reduction of (reg[i] AND Aselect[i]); B operand uses Bselect the same way. Register 0 always reads 0.
  - Forwarding priority for each operand: EX path > WB path > register file. Neither path forwards when the matching select bit is bit 0.
  - EX path: the cycle-N select ANDed with the current-cycle Dselect is nonzero and the op is valid. Forward the combinational ALU result.
  - WB path: the select ANDed with dsel_wb is nonzero. Forward dbus.
  - At the clk edge, latch a_q, b_q and imm_q = sign-extend(ibus0[15:0]).
- Cycle N+1 (execute):
  - abus = a_q; bbus = Imm ? imm_q : b_q.
  - ALU, all results modulo 2^32:
    - S=010: abus+bbus+Cin
    - S=011: abus+~bbus+Cin (Cin=1 gives subtract)
    - S=000: XOR
    - S=110: AND
    - S=100: OR
    - any other S is invalid: the result is still latched, but the write is suppressed.
  - At the edge: dbus = ALU result; dsel_wb = valid ? Dselect : 0.
- Cycle N+2 (write-back):
  - at the edge, reg[i] = dbus for each i with dsel_wb[i]=1 and i != 0.
- Latency: 2 clocks from the read cycle to dbus; the register file is updated 3 edges after the read cycle.
- Select-bus edge cases:
  - A non-one-hot Aselect/Bselect yields the OR of the selected registers.
  - An all-zero select reads 0.
  - A multi-hot dsel_wb writes every selected register.
- Reset mid-pipeline: in-flight results are discarded, no write occurs, and forwarding starts clean.

Decomposition:
- Shared package holds:
  - ALU op constants ALU_XOR=3'b000, ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_OR=3'b100, ALU_AND=3'b110, ALU_INV=3'b111
  - WIDTH and NREG.
- One sub-module is natural: alu32 (combinational; inputs a, b, S, Cin; outputs result and valid).
- The register file with one-hot read/write stays inline.

Test Plan:
- Reset: assert reset for 2 cycles with garbage inputs -> abus=bbus=dbus=0; then read every register -> all 0.
- Immediate load then back-to-back add, all without stalls:
  - addi r1,r0,5 (op 000011) -> dbus=5
  - addi r2,r0,0xFFFD (sign-extended -3) -> dbus=0xFFFFFFFD
  - add r3,r1,r2 issued in the next cycle -> abus=5 via WB forward, bbus=0xFFFFFFFD via EX forward, dbus=2.
- Subtract and logic ops with r1=0x0F0F, r2=0x00FF:
  - sub -> 0x0E10
  - and -> 0x000F
  - or -> 0x0FFF
  - xor -> 0x0FF0
- Register 0: add r0,r1,r1 with r1=7 -> dbus=14, r0 still reads 0; the following instruction reading r0 gets no forward -> abus=0.
- Invalid op S=111 with Dselect=r4 -> dbus latched, but r4 keeps its prior value (e.g. 0x1234).
- Reset mid-operation: add r5,r1,r1 in EX when reset asserts -> r5 stays 0; dbus=0 the next cycle.
